tile_spawner: RTL and testbench

- Implements the GEN step of the 2048 datapath, the counterpart to the row-merge logic: merge removes tiles, this block adds exactly one new tile.
- Accepts the post-merge 4x4 board and picks an empty cell using an on-board 16-bit LFSR.
- Writes exponent 1 (tile "2") or exponent 2 (tile "4") into that cell, returns the board and reports whether the board was full.
- Sequential search, one cell per clock, with a start/done handshake to the top-level FSM.

---
 rtl/tile_spawner.sv | 134 +++++++++++++
 tb/tb_tile_spawner.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/tile_spawner.sv
// Adds one new tile (exponent 1 or 2) to the first empty cell found from an LFSR-picked start index.
// Latency: done k+2 cycles after accepted start (k = offset of first empty cell), 17 cycles if board full.
// Backpressure: none queued; start is only sampled in IDLE, pulses while busy are dropped.
module tile_spawner #(
    parameter int          RANGE = 4,
    parameter int          CELLS = 16,
    parameter logic [15:0] SEED  = 16'hACE1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [RANGE*CELLS-1:0] board_in,
    input  logic                   seed_load,
    input  logic [15:0]            seed_val,
    output logic [RANGE*CELLS-1:0] board_out,
    output logic                   done,
    output logic                   busy,
    output logic                   full,
    output logic [3:0]             spawned_idx
);

    localparam int          BW       = RANGE * CELLS;
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SEARCH = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [15:0]      lfsr_q, lfsr_d;
    logic [BW-1:0]    board_q, board_d;
    logic [BW-1:0]    board_out_q, board_out_d;
    logic [3:0]       idx_q, idx_d;
    logic [3:0]       vsel_q, vsel_d;
    logic [3:0]       steps_q, steps_d;
    logic             full_q, full_d;
    logic [3:0]       spawned_idx_q, spawned_idx_d;

    logic [RANGE-1:0] cells [CELLS];
    logic [RANGE-1:0] cur_cell;
    logic [RANGE-1:0] new_val;
    logic [BW-1:0]    board_new;

    always_comb begin
        board_new = board_q;
        new_val   = (vsel_q != 4'd0) ? RANGE'(1) : RANGE'(2);
        for (int i = 0; i < CELLS; i++) begin
            cells[i] = board_q[RANGE*i +: RANGE];
            if (4'(i) == idx_q) begin
                board_new[RANGE*i +: RANGE] = new_val;
            end
        end
        cur_cell = cells[idx_q];
    end

    always_comb begin
        state_d       = state_q;
        board_d       = board_q;
        board_out_d   = board_out_q;
        idx_d         = idx_q;
        vsel_d        = vsel_q;
        steps_d       = steps_q;
        full_d        = full_q;
        spawned_idx_d = spawned_idx_q;

        // Load wins over stepping; a zero seed would lock the LFSR, so it maps to 1.
        if (seed_load) begin
            lfsr_d = (seed_val == 16'h0000) ? 16'h0001 : seed_val;
        end else begin
            lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    board_d = board_in;
                    idx_d   = lfsr_q[3:0];
                    vsel_d  = lfsr_q[7:4];
                    steps_d = 4'd0;
                    state_d = S_SEARCH;
                end
            end
            S_SEARCH: begin
                if (cur_cell == '0) begin
                    board_d       = board_new;
                    board_out_d   = board_new;
                    spawned_idx_d = idx_q;
                    full_d        = 1'b0;
                    state_d       = S_DONE;
                end else if (steps_q == 4'(CELLS - 1)) begin
                    board_out_d = board_q;
                    full_d      = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    idx_d   = idx_q + 4'd1;
                    steps_d = steps_q + 4'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            lfsr_q        <= SEED_EFF;
            board_q       <= '0;
            board_out_q   <= '0;
            idx_q         <= 4'd0;
            vsel_q        <= 4'd0;
            steps_q       <= 4'd0;
            full_q        <= 1'b0;
            spawned_idx_q <= 4'd0;
        end else begin
            state_q       <= state_d;
            lfsr_q        <= lfsr_d;
            board_q       <= board_d;
            board_out_q   <= board_out_d;
            idx_q         <= idx_d;
            vsel_q        <= vsel_d;
            steps_q       <= steps_d;
            full_q        <= full_d;
            spawned_idx_q <= spawned_idx_d;
        end
    end

    assign board_out   = board_out_q;
    assign done        = (state_q == S_DONE);
    assign busy        = (state_q != S_IDLE);
    assign full        = full_q;
    assign spawned_idx = spawned_idx_q;

endmodule

// File: tb/tb_tile_spawner.sv
// Directed bench for tile_spawner: each task drives one scenario and checks against hand-derived values.
module tb_tile_spawner;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [63:0] board_in = '0;
    logic        seed_load = 1'b0;
    logic [15:0] seed_val = '0;
    logic [63:0] board_out;
    logic        done;
    logic        busy;
    logic        full;
    logic [3:0]  spawned_idx;

    int checks = 0;
    int failures = 0;

    tile_spawner #(.RANGE(4), .CELLS(16), .SEED(16'hACE1)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .board_in    (board_in),
        .seed_load   (seed_load),
        .seed_val    (seed_val),
        .board_out   (board_out),
        .done        (done),
        .busy        (busy),
        .full        (full),
        .spawned_idx (spawned_idx)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] with_cell(input logic [63:0] b, input int i, input logic [3:0] v);
        logic [63:0] r;
        r = b;
        r[4*i +: 4] = v;
        return r;
    endfunction

    // Seed load in one cycle, start in the next; lat counts cycles from the start cycle to done.
    task automatic spawn(input logic [15:0] sv, input logic [63:0] b, output int lat);
        @(negedge clk);
        seed_load = 1'b1;
        seed_val  = sv;
        @(negedge clk);
        seed_load = 1'b0;
        start     = 1'b1;
        board_in  = b;
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", full); end
        checks++; if (board_out !== 64'h0) begin failures++; $display("FAIL reset_board got=%h exp=0", board_out); end
        checks++; if (spawned_idx !== 4'd0) begin failures++; $display("FAIL reset_idx got=%0d exp=0", spawned_idx); end
        rst = 1'b1;
    endtask

    task automatic test_empty_board();
        int lat;
        spawn(16'h0035, 64'h0, lat);
        checks++; if (lat !== 2) begin failures++; $display("FAIL empty_latency got=%0d exp=2", lat); end
        checks++; if (board_out !== with_cell(64'h0, 5, 4'd1)) begin failures++; $display("FAIL empty_board got=%h exp=%h", board_out, with_cell(64'h0, 5, 4'd1)); end
        checks++; if (spawned_idx !== 4'd5) begin failures++; $display("FAIL empty_idx got=%0d exp=5", spawned_idx); end
        checks++; if (full !== 1'b0) begin failures++; $display("FAIL empty_full got=%b exp=0", full); end
    endtask

    task automatic test_occupied_run();
        int lat;
        logic [63:0] b;
        b = with_cell(with_cell(with_cell(64'h0, 5, 4'd3), 6, 4'd3), 7, 4'd3);
        spawn(16'h0035, b, lat);
        checks++; if (lat !== 5) begin failures++; $display("FAIL run_latency got=%0d exp=5", lat); end
        checks++; if (board_out !== with_cell(b, 8, 4'd1)) begin failures++; $display("FAIL run_board got=%h exp=%h", board_out, with_cell(b, 8, 4'd1)); end
        checks++; if (spawned_idx !== 4'd8) begin failures++; $display("FAIL run_idx got=%0d exp=8", spawned_idx); end
    endtask

    task automatic test_wrap();
        int lat;
        logic [63:0] b;
        b = with_cell(64'h2222_2222_2222_2222, 0, 4'd0);
        spawn(16'h000F, b, lat);
        checks++; if (lat !== 3) begin failures++; $display("FAIL wrap_latency got=%0d exp=3", lat); end
        checks++; if (board_out !== with_cell(b, 0, 4'd2)) begin failures++; $display("FAIL wrap_board got=%h exp=%h", board_out, with_cell(b, 0, 4'd2)); end
        checks++; if (spawned_idx !== 4'd0) begin failures++; $display("FAIL wrap_idx got=%0d exp=0", spawned_idx); end
    endtask

    task automatic test_full_board();
        int lat;
        logic [63:0] b;
        b = 64'h1111_1111_1111_1111;
        spawn(16'h0035, b, lat);
        checks++; if (lat !== 17) begin failures++; $display("FAIL full_latency got=%0d exp=17", lat); end
        checks++; if (full !== 1'b1) begin failures++; $display("FAIL full_flag got=%b exp=1", full); end
        checks++; if (board_out !== b) begin failures++; $display("FAIL full_board got=%h exp=%h", board_out, b); end
        checks++; if (spawned_idx !== 4'd0) begin failures++; $display("FAIL full_idx_held got=%0d exp=0", spawned_idx); end
        spawn(16'h0035, 64'h0, lat);
        checks++; if (full !== 1'b0) begin failures++; $display("FAIL full_clear got=%b exp=0", full); end
        checks++; if (spawned_idx !== 4'd5) begin failures++; $display("FAIL full_next_idx got=%0d exp=5", spawned_idx); end
    endtask

    task automatic test_seed_zero();
        int lat;
        spawn(16'h0000, 64'h0, lat);
        checks++; if (lat !== 2) begin failures++; $display("FAIL seed0_latency got=%0d exp=2", lat); end
        checks++; if (board_out !== with_cell(64'h0, 1, 4'd2)) begin failures++; $display("FAIL seed0_board got=%h exp=%h", board_out, with_cell(64'h0, 1, 4'd2)); end
        checks++; if (spawned_idx !== 4'd1) begin failures++; $display("FAIL seed0_idx got=%0d exp=1", spawned_idx); end
    endtask

    task automatic test_busy_ignore();
        int n_done = 0;
        int done_cyc = 0;
        logic [63:0] prev;
        prev = with_cell(64'h0, 1, 4'd2);
        @(negedge clk);
        start    = 1'b1;
        board_in = 64'h1111_1111_1111_1111;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (done) begin n_done++; done_cyc = i; end
            if (i == 1) begin
                checks++; if (busy !== 1'b1) begin failures++; $display("FAIL busy_high got=%b exp=1", busy); end
                board_in = 64'h0;
            end
            if (i == 8) begin
                checks++; if (board_out !== prev) begin failures++; $display("FAIL busy_board_stable got=%h exp=%h", board_out, prev); end
            end
            start = (i == 3 || i == 5 || i == 9);
        end
        checks++; if (n_done !== 1) begin failures++; $display("FAIL busy_done_count got=%0d exp=1", n_done); end
        checks++; if (done_cyc !== 17) begin failures++; $display("FAIL busy_done_cycle got=%0d exp=17", done_cyc); end
        checks++; if (full !== 1'b1) begin failures++; $display("FAIL busy_full got=%b exp=1", full); end
    endtask

    task automatic test_back_to_back();
        int n_done = 0;
        @(negedge clk);
        start    = 1'b1;
        board_in = 64'h0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        start = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (n_done !== 3) begin failures++; $display("FAIL b2b_done_count got=%0d exp=3", n_done); end
    endtask

    task automatic test_reset_mid_search();
        int lat;
        @(negedge clk);
        start    = 1'b1;
        board_in = 64'h1111_1111_1111_1111;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL arst_busy got=%b exp=0", busy); end
        checks++; if (board_out !== 64'h0) begin failures++; $display("FAIL arst_board got=%h exp=0", board_out); end
        checks++; if (done !== 1'b0 || full !== 1'b0 || spawned_idx !== 4'd0) begin failures++; $display("FAIL arst_flags got=%b%b%0d exp=000", done, full, spawned_idx); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL arst_idle got=%b%b exp=00", done, busy); end
        start    = 1'b1;
        board_in = 64'h0;
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        checks++; if (lat !== 2) begin failures++; $display("FAIL arst_latency got=%0d exp=2", lat); end
        checks++; if (spawned_idx !== 4'd3) begin failures++; $display("FAIL arst_seed_idx got=%0d exp=3", spawned_idx); end
        checks++; if (board_out !== with_cell(64'h0, 3, 4'd1)) begin failures++; $display("FAIL arst_seed_board got=%h exp=%h", board_out, with_cell(64'h0, 3, 4'd1)); end
    endtask

    initial begin
        test_reset();
        test_empty_board();
        test_occupied_run();
        test_wrap();
        test_full_board();
        test_seed_zero();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid_search();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
